// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH register array.
// One synchronous write port and two combinational read ports.
// Register 0 always reads as zero. rst (active-low) clears the array at once.
// There is no write-to-read bypass: a read of the register being written
// shows the old value until the clock edge commits the write.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Storage for registers 1..NUM_REGS-1. Register 0 has no storage.
  logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

  // Read view of the whole array, with entry 0 tied to zero.
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  // One-hot write strobe per register.
  logic [NUM_REGS-1:0]   w_wr_en;

  assign w_regs[0]  = '0;
  assign w_wr_en[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    assign w_wr_en[g] = we && (rd == ADDR_WIDTH'(g));
    assign w_regs[g]  = r_regs[g];

    // Per-register storage: async clear takes priority over any write.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_regs[g] <= '0;
      end else if (w_wr_en[g]) begin
        r_regs[g] <= dataIn;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    A = w_regs[rs];
    B = w_regs[rt];
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// A reference array tracks the expected contents; every read pushes the
// expected A and B values to exp_q, which are popped and compared against
// the DUT outputs once the combinational reads have settled.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] rd;
  logic [DW-1:0] dataIn;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] A;
  logic [DW-1:0] B;

  int            n_checks;
  int            n_errors;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [NR];

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .rd    (rd),
    .dataIn(dataIn),
    .rs    (rs),
    .rt    (rt),
    .A     (A),
    .B     (B)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  // Scoreboard: pop expected A then B and compare with the DUT.
  task automatic pop_check(input string tag);
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    #1;
    if (exp_q.size() < 2) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %0d entries expected 2", tag, exp_q.size());
    end else begin
      exp_a = exp_q.pop_front();
      exp_b = exp_q.pop_front();
      check_eq({tag, "_A"}, A, exp_a);
      check_eq({tag, "_B"}, B, exp_b);
    end
  endtask

  // Driver: set read addresses, push expected values, then compare.
  task automatic read_ab(input string tag, input logic [AW-1:0] a_addr,
                         input logic [AW-1:0] b_addr);
    rs = a_addr;
    rt = b_addr;
    exp_q.push_back(model[a_addr]);
    exp_q.push_back(model[b_addr]);
    pop_check(tag);
  endtask

  // Driver: one write cycle, inputs changed on the falling edge.
  task automatic write_reg(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    we     = 1'b1;
    rd     = addr;
    dataIn = data;
    @(posedge clk);
    if (rst && addr != '0) model[addr] = data;
    #1;
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    rst    = 1'b0;
    we     = 1'b0;
    rd     = '0;
    dataIn = '0;
    rs     = '0;
    rt     = '0;

    // Reads during reset, and a write attempt across an edge while in reset.
    #2;
    read_ab("in_rst", 5'd1, 5'd30);
    we = 1'b1; rd = 5'd3; dataIn = 32'hCAFEF00D;
    @(posedge clk); #1;
    read_ab("in_rst_wr", 5'd3, 5'd3);
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;

    // Idle clocks after reset keep everything zero.
    read_ab("post_rst", 5'd1, 5'd30);
    repeat (3) @(posedge clk);
    #1;
    read_ab("idle_clk", 5'd1, 5'd30);

    // Write r1: old value visible before the edge, new value after it.
    @(negedge clk);
    we = 1'b1; rd = 5'd1; dataIn = 32'h1002AAFF;
    read_ab("no_bypass", 5'd1, 5'd1);
    @(posedge clk);
    model[1] = 32'h1002AAFF;
    #1;
    we = 1'b0;
    read_ab("wr_r1", 5'd1, 5'd0);

    // Writes to r0 are discarded.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_ab("r0_zero", 5'd0, 5'd0);

    // Consecutive writes, then we=0 leaves r2 unchanged.
    write_reg(5'd2, 32'h1002ABB8);
    write_reg(5'd31, 32'h1002AC71);
    read_ab("r2_r31", 5'd2, 5'd31);
    @(negedge clk);
    we = 1'b0; rd = 5'd2; dataIn = 32'h12345678;
    @(posedge clk); #1;
    read_ab("we_low", 5'd2, 5'd31);

    // Mid-operation asynchronous reset with we held high.
    write_reg(5'd5, 32'hDEADBEEF);
    read_ab("r5_set", 5'd5, 5'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    we = 1'b1; rd = 5'd5; dataIn = 32'h5555AAAA;
    model_clear();
    read_ab("async_clr", 5'd5, 5'd2);
    repeat (2) @(posedge clk);
    #1;
    read_ab("rst_hold", 5'd5, 5'd31);
    @(negedge clk);
    we = 1'b0;
    #2;
    rst = 1'b1;
    read_ab("rst_release", 5'd5, 5'd1);
    @(posedge clk); #1;
    read_ab("after_release", 5'd5, 5'd5);

    // Sweep every register with distinct data.
    for (int i = 1; i < NR; i++) begin
      logic [DW-1:0] d;
      d = (DW'(i) << 24) | DW'($urandom_range(0, 32'h00FFFFFF));
      write_reg(AW'(i), d);
      read_ab("sweep_wr", AW'(i), AW'(i));
    end
    for (int i = 0; i < NR; i++) begin
      read_ab("sweep_rb", AW'(i), AW'(NR - 1 - i));
    end

    // Random read address pairs over the filled array.
    for (int i = 0; i < 16; i++) begin
      read_ab("rand_rd", AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
